fb_write_scheduler: RTL and testbench

FB_WRITE_SCHEDULER -- requirements
Module: fb_write_scheduler

---
 rtl/fb_write_scheduler_if.sv | 32 +++
 rtl/fb_write_scheduler.sv | 137 +++++++++++++
 tb/tb_fb_write_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_scheduler_if.sv
// Framebuffer write scheduler bus: write window, two requester
// handshakes, clear control and the registered memory write port.
// master: requester/system side; slave: the scheduler.
interface fb_write_scheduler_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) ();
    logic              win;
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              gnt0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              gnt1;
    logic              clr_start;
    logic              clr_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output win, req0, addr0, data0, req1, addr1, data1, clr_start,
        input  gnt0, gnt1, clr_busy, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  win, req0, addr0, data0, req1, addr1, data1, clr_start,
        output gnt0, gnt1, clr_busy, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: round-robin arbitration of two pixel
// writers inside the write window, plus an optional full clear sweep.
// Ports: clk, rst (async, active high), bus (fb_write_scheduler_if.slave):
//   win, req0/addr0/data0/gnt0, req1/addr1/data1/gnt1,
//   clr_start, clr_busy, wr_en/wr_addr/wr_data (registered, latency 1).
// Macro FB_WRITE_SCHEDULER_CLEAR_EN enables the CLEAR sweep; when it is
// undefined clr_start is ignored and clr_busy stays 0.
module fb_write_scheduler #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 8,
    parameter int                CLR_LAST  = 1023,
    parameter logic [DATA_W-1:0] CLR_COLOR = 8'h00
) (
    input  logic                 clk,
    input  logic                 rst,
    fb_write_scheduler_if.slave  bus
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_busy_q, clr_busy_d;
    logic              last_q, last_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic clr_go;
    logic clr_issue;
    logic can_arb;
    logic g0;
    logic g1;

`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CLR_LAST);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_busy_d = clr_busy_q;
        clr_go     = 1'b0;
        clr_issue  = 1'b0;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
        unique case (state_q)
            IDLE: begin
                if (bus.clr_start) begin
                    clr_go     = 1'b1;
                    state_d    = CLEAR;
                    cnt_d      = '0;
                    clr_busy_d = 1'b1;
                end
            end
            CLEAR: begin
                // Sweep only advances inside the write window.
                if (bus.win) begin
                    clr_issue = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        clr_busy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
`endif
    end

    // A clear request in IDLE takes the cycle, so no grant alongside it.
    // last_q = 1 means requester 1 was served last, so 0 wins a tie.
    always_comb begin
        can_arb = !rst && bus.win && (state_q == IDLE) && !clr_go;
        g0      = can_arb && bus.req0 && (!bus.req1 || last_q);
        g1      = can_arb && bus.req1 && (!bus.req0 || !last_q);
        last_d  = last_q;
        if (g0) begin
            last_d = 1'b0;
        end else if (g1) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        wr_en_d   = clr_issue || g0 || g1;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        unique case (1'b1)
            clr_issue: begin
                wr_addr_d = cnt_q;
                wr_data_d = CLR_COLOR;
            end
            g0: begin
                wr_addr_d = bus.addr0;
                wr_data_d = bus.data0;
            end
            g1: begin
                wr_addr_d = bus.addr1;
                wr_data_d = bus.data1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_busy_q <= 1'b0;
            last_q     <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_busy_q <= clr_busy_d;
            last_q     <= last_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign bus.gnt0     = g0;
    assign bus.gnt1     = g1;
    assign bus.clr_busy = clr_busy_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// Self-checking bench for fb_write_scheduler: directed vector table,
// clear/reset sequences and randomized traffic against a reference model.
module tb_fb_write_scheduler;

    localparam int CLR_LAST = 3;
`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fb_write_scheduler_if #(.ADDR_W(10), .DATA_W(8)) bus ();

    fb_write_scheduler #(
        .ADDR_W   (10),
        .DATA_W   (8),
        .CLR_LAST (CLR_LAST),
        .CLR_COLOR(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       win;
        logic       r0;
        logic [9:0] a0;
        logic [7:0] d0;
        logic       r1;
        logic [9:0] a1;
        logic [7:0] d1;
        logic       g0;
        logic       g1;
        logic       wen;
        logic [9:0] wa;
        logic [7:0] wd;
    } vec_t;

    vec_t tbl[12];

    // reference model state
    int         m_last;
    bit         m_clr;
    int         m_cnt;
    logic       e_wen;
    logic [9:0] e_addr;
    logic [7:0] e_data;
    logic       e_busy;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic w, input logic r0, input int a0, input int d0,
        input logic r1, input int a1, input int d1,
        input logic g0, input logic g1, input logic wen,
        input int wa, input int wd);
        vec_t v;
        v.win = w;
        v.r0  = r0; v.a0 = 10'(a0); v.d0 = 8'(d0);
        v.r1  = r1; v.a1 = 10'(a1); v.d1 = 8'(d1);
        v.g0  = g0; v.g1 = g1; v.wen = wen;
        v.wa  = 10'(wa); v.wd = 8'(wd);
        return v;
    endfunction

    task automatic model_init();
        m_last = 1;
        m_clr  = 1'b0;
        m_cnt  = 0;
        e_wen  = 1'b0;
        e_addr = '0;
        e_data = '0;
        e_busy = 1'b0;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.win       = 1'b1;
        bus.req0      = 1'b1;
        bus.req1      = 1'b1;
        bus.clr_start = 1'b0;
        bus.addr0     = 10'h3;
        bus.data0     = 8'h33;
        bus.addr1     = 10'h4;
        bus.data1     = 8'h44;
        #1;
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 0);
        chk("rst_wr_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(bus.clr_busy), 0);
        tick();
        tick();
        rst      = 1'b0;
        bus.win  = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        model_init();
    endtask

    // Winner is whoever requests alone, or the one not served last.
    task automatic model_grant(output logic g0, output logic g1);
        bit ok;
        ok = bus.win && !m_clr && !(CLR_EN && bus.clr_start);
        g0 = 1'b0;
        g1 = 1'b0;
        if (ok) begin
            if (bus.req0 && bus.req1) begin
                if (m_last == 0) g1 = 1'b1;
                else g0 = 1'b1;
            end else begin
                g0 = bus.req0;
                g1 = bus.req1;
            end
        end
    endtask

    task automatic model_advance(input logic g0, input logic g1);
        e_wen = 1'b0;
        if (m_clr) begin
            if (bus.win) begin
                e_wen  = 1'b1;
                e_addr = 10'(m_cnt);
                e_data = 8'h00;
                if (m_cnt == CLR_LAST) m_clr = 1'b0;
                else m_cnt++;
            end
        end else if (CLR_EN && bus.clr_start) begin
            m_clr = 1'b1;
            m_cnt = 0;
        end else if (g0) begin
            e_wen  = 1'b1;
            e_addr = bus.addr0;
            e_data = bus.data0;
            m_last = 0;
        end else if (g1) begin
            e_wen  = 1'b1;
            e_addr = bus.addr1;
            e_data = bus.data1;
            m_last = 1;
        end
        e_busy = m_clr;
    endtask

    initial begin
        logic eg0, eg1;
        bit   p0, p1;
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.win = 1'b0; bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.clr_start = 1'b0;
        bus.addr0 = '0; bus.data0 = '0; bus.addr1 = '0; bus.data1 = '0;
        #2;

        // win r0 a0 d0 r1 a1 d1 | g0 g1 wen wa wd
        tbl[0]  = mk(1, 1, 1, 'h11, 1, 2, 'h22, 1, 0, 0, 0, 0);
        tbl[1]  = mk(1, 1, 3, 'h33, 1, 2, 'h22, 0, 1, 1, 1, 'h11);
        tbl[2]  = mk(1, 1, 3, 'h33, 1, 4, 'h44, 1, 0, 1, 2, 'h22);
        tbl[3]  = mk(1, 1, 5, 'h55, 1, 4, 'h44, 0, 1, 1, 3, 'h33);
        tbl[4]  = mk(1, 1, 5, 'hE0, 0, 0, 0, 1, 0, 1, 4, 'h44);
        tbl[5]  = mk(0, 0, 0, 0, 1, 7, 'h77, 0, 0, 1, 5, 'hE0);
        tbl[6]  = mk(0, 0, 0, 0, 1, 7, 'h77, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 0, 0, 0, 1, 7, 'h77, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 0, 0, 0, 1, 7, 'h77, 0, 1, 0, 0, 0);
        tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 'h77);
        tbl[10] = mk(1, 1, 8, 'h88, 1, 9, 'h99, 1, 0, 0, 0, 0);
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 'h88);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.win   = tbl[i].win;
            bus.req0  = tbl[i].r0;
            bus.addr0 = tbl[i].a0;
            bus.data0 = tbl[i].d0;
            bus.req1  = tbl[i].r1;
            bus.addr1 = tbl[i].a1;
            bus.data1 = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d_gnt0", i), 32'(bus.gnt0), 32'(tbl[i].g0));
            chk($sformatf("tbl%0d_gnt1", i), 32'(bus.gnt1), 32'(tbl[i].g1));
            chk($sformatf("tbl%0d_wr_en", i), 32'(bus.wr_en),
                32'(tbl[i].wen));
            if (tbl[i].wen) begin
                chk($sformatf("tbl%0d_wr_addr", i), 32'(bus.wr_addr),
                    32'(tbl[i].wa));
                chk($sformatf("tbl%0d_wr_data", i), 32'(bus.wr_data),
                    32'(tbl[i].wd));
            end
            tick();
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

`ifdef FB_WRITE_SCHEDULER_CLEAR_EN
        // clear sweep with a competing request
        do_reset();
        bus.win = 1'b1; bus.req0 = 1'b1;
        bus.addr0 = 10'h10; bus.data0 = 8'h5A;
        bus.clr_start = 1'b1;
        #1;
        chk("clr_start_gnt0", 32'(bus.gnt0), 0);
        chk("clr_start_busy", 32'(bus.clr_busy), 0);
        tick();
        bus.clr_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            chk($sformatf("clr%0d_busy", i), 32'(bus.clr_busy), 1);
            chk($sformatf("clr%0d_gnt0", i), 32'(bus.gnt0), 0);
            chk($sformatf("clr%0d_wr_en", i), 32'(bus.wr_en),
                32'(i >= 2));
            if (i >= 2) begin
                chk($sformatf("clr%0d_wr_addr", i), 32'(bus.wr_addr),
                    32'(i - 2));
                chk($sformatf("clr%0d_wr_data", i), 32'(bus.wr_data), 0);
            end
            tick();
        end
        #1;
        chk("clr_end_busy", 32'(bus.clr_busy), 0);
        chk("clr_end_gnt0", 32'(bus.gnt0), 1);
        chk("clr_end_wr_addr", 32'(bus.wr_addr), 3);
        chk("clr_end_wr_en", 32'(bus.wr_en), 1);
        tick();
        bus.req0 = 1'b0;
        #1;
        chk("clr_after_wr_addr", 32'(bus.wr_addr), 32'h10);
        chk("clr_after_wr_data", 32'(bus.wr_data), 32'h5A);
        tick();

        // reset during the sweep
        do_reset();
        bus.win = 1'b1;
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        tick();
        tick();
        #1;
        chk("abort_pre_wr_addr", 32'(bus.wr_addr), 1);
        chk("abort_pre_wr_en", 32'(bus.wr_en), 1);
        rst = 1'b1;
        bus.req0 = 1'b1;
        #1;
        chk("abort_wr_en", 32'(bus.wr_en), 0);
        chk("abort_wr_addr", 32'(bus.wr_addr), 0);
        chk("abort_busy", 32'(bus.clr_busy), 0);
        chk("abort_gnt0", 32'(bus.gnt0), 0);
        tick();
        rst = 1'b0;
        bus.req0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("abort_post%0d_wr_en", i), 32'(bus.wr_en), 0);
            chk($sformatf("abort_post%0d_busy", i), 32'(bus.clr_busy), 0);
            tick();
        end
`else
        // clr_start has no effect without the clear feature
        do_reset();
        bus.win = 1'b1; bus.req0 = 1'b1;
        bus.addr0 = 10'h3; bus.data0 = 8'h77;
        bus.clr_start = 1'b1;
        #1;
        chk("noclr_gnt0", 32'(bus.gnt0), 1);
        tick();
        bus.clr_start = 1'b0;
        bus.req0 = 1'b0;
        #1;
        chk("noclr_wr_en", 32'(bus.wr_en), 1);
        chk("noclr_wr_addr", 32'(bus.wr_addr), 3);
        tick();
        bus.clr_start = 1'b1;
        tick();
        bus.clr_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("noclr%0d_wr_en", i), 32'(bus.wr_en), 0);
            chk($sformatf("noclr%0d_busy", i), 32'(bus.clr_busy), 0);
            tick();
        end
`endif

        // randomized traffic against the model
        do_reset();
        p0 = 1'b0;
        p1 = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.win = ($urandom_range(3) != 0);
            if (!p0 && $urandom_range(1) == 1) begin
                p0 = 1'b1;
                bus.addr0 = 10'($urandom);
                bus.data0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(1) == 1) begin
                p1 = 1'b1;
                bus.addr1 = 10'($urandom);
                bus.data1 = 8'($urandom);
            end
            bus.req0 = p0;
            bus.req1 = p1;
            bus.clr_start = ($urandom_range(29) == 0);
            #1;
            model_grant(eg0, eg1);
            chk("rnd_gnt0", 32'(bus.gnt0), 32'(eg0));
            chk("rnd_gnt1", 32'(bus.gnt1), 32'(eg1));
            chk("rnd_wr_en", 32'(bus.wr_en), 32'(e_wen));
            chk("rnd_busy", 32'(bus.clr_busy), 32'(e_busy));
            if (e_wen) begin
                chk("rnd_wr_addr", 32'(bus.wr_addr), 32'(e_addr));
                chk("rnd_wr_data", 32'(bus.wr_data), 32'(e_data));
            end
            model_advance(eg0, eg1);
            if (eg0) p0 = 1'b0;
            if (eg1) p1 = 1'b0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
